// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unary_pkg
//  Description : Shared types and sizing helpers for the temporal unary
//                decoder (FSM state encoding, window length, result width).
//  Revision    : 1.0 - initial release
// ============================================================================
package unary_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Cycles per data window: encoder counter period (2^size + 1) plus one
    function automatic int window_len(input int size);
        return (1 << size) + 2;
    endfunction

    // Result width per lane: one extra bit so +2^SIZE and -2^SIZE both fit
    function automatic int out_width(input int bw);
        return bw + 1;
    endfunction

endpackage : unary_pkg
`default_nettype wire

// File: rtl/unary_lane_counter.sv
`default_nettype none
// ============================================================================
//  Module      : unary_lane_counter
//  Description : One unary lane: saturating pulse counter, first-sample sign
//                latch, sticky saturation / sign-error flags and the signed
//                result register loaded on the last sample of the window.
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_lane_counter #(
    parameter int SIZE  = 3,
    parameter int OUT_W = SIZE + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample,
    input  logic             first,
    input  logic             last,
    input  logic             unary_in,
    input  logic             is_negative,
    output logic [OUT_W-1:0] result,
    output logic             sat,
    output logic             sign_err
);
    import unary_pkg::*;

    localparam int               CW      = SIZE + 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(1 << SIZE);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             w_at_max;
    logic [CW-1:0]    w_cnt_next;
    logic             w_sign_now;
    logic [OUT_W-1:0] w_mag;
    logic [OUT_W-1:0] w_signed;

    // Next count including this cycle's pulse, and the signed value it forms.
    // On the first sample the sign comes straight from the input since the
    // latch has not been loaded yet. Negating zero yields zero.
    always_comb begin
        w_at_max   = (r_cnt == CNT_MAX);
        w_cnt_next = (unary_in && !w_at_max) ? (r_cnt + CNT_ONE) : r_cnt;
        w_sign_now = first ? is_negative : r_sign;
        w_mag      = OUT_W'(w_cnt_next);
        w_signed   = w_sign_now ? (~w_mag + OUT_ONE) : w_mag;
    end

    // Per-lane state: clear on window start, accumulate while sampling,
    // capture the result on the final sample; result survives a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            sat      <= 1'b0;
            sign_err <= 1'b0;
            result   <= '0;
        end else if (clear) begin
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            sat      <= 1'b0;
            sign_err <= 1'b0;
        end else if (sample) begin
            r_cnt <= w_cnt_next;
            if (unary_in && w_at_max) begin
                sat <= 1'b1;
            end
            if (first) begin
                r_sign <= is_negative;
            end else if (unary_in && (is_negative != r_sign)) begin
                sign_err <= 1'b1;
            end
            if (last) begin
                result <= w_signed;
            end
        end
    end

endmodule : unary_lane_counter
`default_nettype wire

// File: rtl/temporal_unary_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : temporal_unary_decoder
//  Description : Decodes LANES temporal unary pulse trains into signed binary.
//                One window of WINDOW samples per start; the result vector is
//                presented on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporal_unary_decoder
    import unary_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int BIT_WIDTH = 4,
    parameter int SIZE      = BIT_WIDTH - 1,
    parameter int WINDOW    = window_len(SIZE),
    parameter int OUT_W     = out_width(BIT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LANES-1:0]       unary_in,
    input  logic [LANES-1:0]       is_negative,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   out_valid,
    output logic [LANES*OUT_W-1:0] out,
    output logic [LANES-1:0]       sat,
    output logic [LANES-1:0]       sign_err
);

    localparam int                WCNT_W   = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    // A one-sample window cannot separate sign latch from result capture
    if (SIZE < 1) begin : g_size_check
        $error("temporal_unary_decoder: SIZE must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic              w_sample;
    logic              w_first;
    logic              w_last;

    // Lane strobes; start overrides any sampling in the same cycle
    always_comb begin
        w_sample = (r_state == COUNT) && !start;
        w_first  = w_sample && (r_wcnt == '0);
        w_last   = w_sample && (r_wcnt == WIN_LAST);
    end

    // Next state: start wins over window end and over the handshake
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = COUNT;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                COUNT:   if (r_wcnt == WIN_LAST) w_state_next = HOLD;
                HOLD:    if (out_ready)          w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Window cycle counter: zeroed by start, advances once per sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if (start) begin
            r_wcnt <= '0;
        end else if (r_state == COUNT) begin
            r_wcnt <= r_wcnt + WCNT_ONE;
        end else begin
            r_wcnt <= '0;
        end
    end

    assign busy      = (r_state == COUNT);
    assign out_valid = (r_state == HOLD);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        unary_lane_counter #(
            .SIZE  (SIZE),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .clear       (start),
            .sample      (w_sample),
            .first       (w_first),
            .last        (w_last),
            .unary_in    (unary_in[g]),
            .is_negative (is_negative[g]),
            .result      (out[g*OUT_W +: OUT_W]),
            .sat         (sat[g]),
            .sign_err    (sign_err[g])
        );
    end

endmodule : temporal_unary_decoder
`default_nettype wire

// File: tb/tb_temporal_unary_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporal_unary_decoder
//  Description : Scoreboard bench for temporal_unary_decoder with LANES=4,
//                BIT_WIDTH=4 (WINDOW=10, OUT_W=5) and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporal_unary_decoder;

    localparam int LANES     = 4;
    localparam int BIT_WIDTH = 4;
    localparam int WINDOW    = 10;
    localparam int OUT_W     = 5;
    localparam int OW        = LANES * OUT_W;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LANES-1:0] unary_in;
    logic [LANES-1:0] is_negative;
    logic             out_ready;
    logic             busy;
    logic             out_valid;
    logic [OW-1:0]    out;
    logic [LANES-1:0] sat;
    logic [LANES-1:0] sign_err;

    temporal_unary_decoder #(
        .LANES     (LANES),
        .BIT_WIDTH (BIT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .unary_in    (unary_in),
        .is_negative (is_negative),
        .out_ready   (out_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out         (out),
        .sat         (sat),
        .sign_err    (sign_err)
    );

    typedef struct packed {
        logic [OW-1:0]    o;
        logic [LANES-1:0] s;
        logic [LANES-1:0] e;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per accepted result (valid & ready, no start)
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready && !start) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got out=%h expected no result", out);
            end else begin
                e = sb.pop_front();
                chk("result_out",      32'(out),      32'(e.o));
                chk("result_sat",      32'(sat),      32'(e.s));
                chk("result_sign_err", 32'(sign_err), 32'(e.e));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [OW-1:0] o, input logic [LANES-1:0] s, input logic [LANES-1:0] e);
        exp_t x;
        x.o = o;
        x.s = s;
        x.e = e;
        sb.push_back(x);
    endtask

    // Lane l pulses on samples 0..n_l-1; constant sign vector over the window
    task automatic mk(input int n0, input int n1, input int n2, input int n3,
                      input logic [LANES-1:0] sg,
                      output logic [WINDOW-1:0][LANES-1:0] pu,
                      output logic [WINDOW-1:0][LANES-1:0] ng);
        for (int i = 0; i < WINDOW; i++) begin
            pu[i] = {i < n3, i < n2, i < n1, i < n0};
            ng[i] = sg;
        end
    endtask

    // Drives all WINDOW samples; out_valid must rise exactly after the last one
    task automatic do_samples(input logic [WINDOW-1:0][LANES-1:0] pu,
                              input logic [WINDOW-1:0][LANES-1:0] ng);
        for (int i = 0; i < WINDOW; i++) begin
            unary_in    = pu[i];
            is_negative = ng[i];
            step();
            chk("latency_valid", 32'(out_valid), 32'(i == WINDOW - 1));
            chk("latency_busy",  32'(busy),      32'(i != WINDOW - 1));
        end
        unary_in    = '0;
        is_negative = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WINDOW-1:0][LANES-1:0] pu;
        logic [WINDOW-1:0][LANES-1:0] ng;

        reset       = 1'b1;
        start       = 1'b0;
        unary_in    = '0;
        is_negative = '0;
        out_ready   = 1'b1;
        step();
        step();
        chk("reset_valid",    32'(out_valid), 32'd0);
        chk("reset_busy",     32'(busy),      32'd0);
        chk("reset_out",      32'(out),       32'd0);
        chk("reset_sat",      32'(sat),       32'd0);
        chk("reset_sign_err", 32'(sign_err),  32'd0);
        reset = 1'b0;
        step();

        // Basic: lane0 +5, lane1 -3
        mk(5, 3, 0, 0, 4'b0010, pu, ng);
        push(20'h003A5, 4'b0000, 4'b0000);
        do_start();
        do_samples(pu, ng);
        step();
        chk("accept_valid", 32'(out_valid), 32'd0);
        chk("accept_busy",  32'(busy),      32'd0);

        // Full negative magnitude: -8
        mk(8, 0, 0, 0, 4'b0001, pu, ng);
        push(20'h00018, 4'b0000, 4'b0000);
        do_start();
        do_samples(pu, ng);
        step();

        // Ten pulses: clamp to +8 and flag sat
        mk(10, 0, 0, 0, 4'b0000, pu, ng);
        push(20'h00008, 4'b0001, 4'b0000);
        do_start();
        do_samples(pu, ng);
        step();

        // Backpressure with junk inputs during HOLD
        out_ready = 1'b0;
        mk(2, 4, 6, 1, 4'b1010, pu, ng);
        push(20'hF9B82, 4'b0000, 4'b0000);
        do_start();
        do_samples(pu, ng);
        unary_in    = '1;
        is_negative = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_out",   32'(out),       32'h000F9B82);
            chk("hold_sat",   32'(sat),       32'd0);
        end
        out_ready = 1'b1;
        step();
        unary_in    = '0;
        is_negative = '0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_busy",  32'(busy),      32'd0);

        // Restart at wcnt=4 after 3 pulses; only the new 2 pulses count
        do_start();
        mk(3, 0, 0, 0, 4'b0000, pu, ng);
        for (int i = 0; i < 4; i++) begin
            unary_in = pu[i];
            step();
        end
        unary_in = '0;
        mk(2, 0, 0, 0, 4'b0000, pu, ng);
        push(20'h00002, 4'b0000, 4'b0000);
        do_start();
        do_samples(pu, ng);
        step();

        // Start during HOLD with out_ready high: result discarded, new window
        out_ready = 1'b0;
        mk(0, 1, 0, 0, 4'b0000, pu, ng);
        do_start();
        do_samples(pu, ng);
        step();
        chk("hold2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        mk(0, 0, 0, 7, 4'b1000, pu, ng);
        push(20'hC8000, 4'b0000, 4'b0000);
        do_start();
        chk("hold_restart_valid", 32'(out_valid), 32'd0);
        chk("hold_restart_busy",  32'(busy),      32'd1);
        do_samples(pu, ng);
        step();

        // Sign error on lane2; lane1 sign flips only while idle (no error)
        mk(0, 2, 3, 0, 4'b0010, pu, ng);
        for (int i = 1; i < WINDOW; i++) ng[i][2] = 1'b1;
        for (int i = 5; i < WINDOW; i++) ng[i][1] = 1'b0;
        push(20'h00FC0, 4'b0000, 4'b0100);
        do_start();
        do_samples(pu, ng);
        step();

        // Asynchronous reset at wcnt=6
        do_start();
        mk(4, 0, 0, 0, 4'b0000, pu, ng);
        for (int i = 0; i < 6; i++) begin
            unary_in = pu[i];
            step();
        end
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_busy",  32'(busy),      32'd0);
        chk("async_reset_out",   32'(out),       32'd0);
        unary_in = '0;
        step();
        reset = 1'b0;
        step();

        // Recovery after reset: all lanes -1
        mk(1, 1, 1, 1, 4'b1111, pu, ng);
        push(20'hFFFFF, 4'b0000, 4'b0000);
        do_start();
        do_samples(pu, ng);
        step();
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_temporal_unary_decoder
`default_nettype wire

// File: doc/temporal_unary_decoder.md
Name: temporal_unary_decoder

Overview:
Converts per-lane temporal unary pulse trains back into signed binary. This is the receive end of the comparator/counter unary encoding used by the temporal MXU: each lane carries `counter < magnitude` pulses plus a sign flag over one data window. The block counts pulses per lane across one window and applies the sign. It presents one result vector per window on a valid/ready handshake. It sits at the output of a unary link, for example a unary bus between MXU tiles or a debug capture path.

Parameters:
- LANES, 16, number of independent unary lanes decoded in parallel.
- BIT_WIDTH, 4, signed two's-complement width of the original encoded value.
- SIZE, BIT_WIDTH-1, magnitude bits; maximum legal magnitude is 2^SIZE (the -2^SIZE case).
- WINDOW, (1<<SIZE)+2, cycles per data window; matches the encoder counter period of 2^SIZE+1 plus one.
- OUT_W, BIT_WIDTH+1, result width per lane; holds -2^SIZE..+2^SIZE.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new window; clears all lane counters.
- unary_in  in  LANES  one unary pulse bit per lane, sampled every window cycle.
- is_negative  in  LANES  per-lane sign flag accompanying unary_in.
- out_ready  in  1  consumer accepts the result when high with out_valid.
- busy  out  1  high while in COUNT.
- out_valid  out  1  result vector valid.
- out  out  LANES x OUT_W  signed decoded values, lane 0 in the LSBs.
- sat  out  LANES  lane saw more than 2^SIZE pulses; its value was clamped.
- sign_err  out  LANES  lane's is_negative changed during the window while its unary_in pulsed.

Behaviour:
- Reset (async, active-high): state IDLE; busy=0; out_valid=0; out=0; sat=0; sign_err=0; all counters 0.
- States and transitions:
  - IDLE: wait for start.
  - COUNT: window cycle counter wcnt runs 0..WINDOW-1.
  - HOLD: result presented, waiting for out_ready.
- start sampled high at edge k, in any state:
  - Next state is COUNT with wcnt=0.
  - All lane counts, sat and sign_err clear.
  - out_valid drops to 0; any unaccepted result is discarded.
  - start always wins over every other event, including a handshake in the same cycle.
- COUNT:
  - unary_in/is_negative are sampled on edges k+1 .. k+WINDOW, which is WINDOW samples.
  - Lane count increments on each sampled 1.
  - Count width is SIZE+1 and saturates at 2^SIZE; a further pulse sets sat[lane] sticky.
- Sign per lane:
  - Latched on the first sample edge (k+1).
  - If a later sample has unary_in=1 and is_negative differs from the latched value, sign_err[lane] is set.
  - The latched sign is kept for the result.
- Window end, on edge k+WINDOW:
  - out[lane] = latched sign ? -count : +count, sign-extended to OUT_W.
  - A negative lane with count 0 yields 0; there is no negative zero.
  - out_valid=1 and state goes to HOLD.
  - Latency from the start edge to out_valid visible is WINDOW edges.
- HOLD:
  - out, sat and sign_err are held stable while out_valid=1 and out_ready=0.
  - When out_valid & out_ready at an edge: out_valid goes to 0 and state goes to IDLE. out, sat and sign_err keep their last values.
  - Inputs unary_in and is_negative are ignored in HOLD and IDLE.
- busy = (state==COUNT).
- Reset mid-COUNT or mid-HOLD returns to IDLE immediately; the partial result is lost.
- WINDOW=1 is not supported; elaboration must fail if SIZE<1.

Decomposition:
- Shared package (unary_pkg):
  - state enum {IDLE, COUNT, HOLD}.
  - Function window_len(size) = (1<<size)+2.
  - Function out_width(bw) = bw+1.
- Sub-module unary_lane_counter, one per lane via generate. It holds:
  - the saturating SIZE+1-bit counter,
  - the sign latch,
  - sat and sign_err flags,
  - signed result formation.
- Top level holds the FSM, wcnt and the handshake.

Test Plan (LANES=4, BIT_WIDTH=4, WINDOW=10):
- Basic decode: start, then lane0 5 pulses with sign 0, lane1 3 pulses with sign 1, lanes2/3 none → out_valid exactly 10 edges after start; out = {0, 0, -3, +5}; sat=0; sign_err=0.
- Full magnitude: lane0 8 pulses with sign 1 → out[0]=-8 (5'b11000). Lane0 10 pulses with sign 0 → out[0]=+8 and sat[0]=1.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid → out stable and out_valid=1 throughout; raise out_ready → out_valid=0 next edge, state IDLE.
- Restart: assert start at wcnt=4 after 3 pulses, then send 2 pulses → result +2, not 5. Assert start in HOLD with out_ready=1 the same cycle → no accept; new window begins.
- Sign error: lane2 sign 0 for the first sample, then 1 during a pulse → sign_err[2]=1; out[2] uses the positive sign.
- Reset: assert reset at wcnt=6 → out_valid=0, out=0, busy=0 immediately, asynchronously.
